// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel-RAM subsystem (160x120 RGB332).
package vga_pkg;

   localparam int unsigned SCR_W      = 160;
   localparam int unsigned SCR_H      = 120;
   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned PIX_COUNT  = SCR_W * SCR_H;
   localparam int unsigned WBUF_DEPTH = 4;
   localparam logic [DATA_W-1:0] CLR_COLOR = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      CLEAR
   } arb_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester/RAM bundle around the pixel-RAM arbiter; slave is the arbiter side.
interface vram_arbiter_if;
   import vga_pkg::*;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_rvalid;
   logic [DATA_W-1:0] vid_rdata;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_req, ram_rdata,
      output vid_rvalid, vid_rdata, wr_ready, clr_busy, clr_done,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_req, ram_rdata,
      input  vid_rvalid, vid_rdata, wr_ready, clr_busy, clr_done,
             ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/vram_wbuf.sv
// Small synchronous FIFO holding game-logic pixel writes until a RAM slot frees up.
module vram_wbuf #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned W     = 23,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q;
   logic [AW-1:0] wr_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel-RAM arbiter: video reads win, then the clear sweep, then buffered game writes.
module vram_arbiter #(
   parameter int unsigned                  PIX_COUNT  = vga_pkg::PIX_COUNT,
   parameter int unsigned                  WBUF_DEPTH = vga_pkg::WBUF_DEPTH,
   parameter logic [vga_pkg::DATA_W-1:0]   CLR_COLOR  = vga_pkg::CLR_COLOR
) (
   input logic           clk,
   input logic           rst_n,
   vram_arbiter_if.slave bus
);
   import vga_pkg::*;

   localparam int unsigned CW = $clog2(WBUF_DEPTH + 1);

   arb_state_t        state_q;
   logic [ADDR_W-1:0] sweep_q;
   logic              ram_en_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              vid_rvalid_q;
   logic              clr_done_q;

   wr_entry_t         push_entry;
   wr_entry_t         head;
   logic              push, pop, full, empty;
   logic [CW-1:0]     count;
   logic              clr_win, buf_win;

   assign push_entry   = '{addr: bus.wr_addr, data: bus.wr_data};
   assign bus.wr_ready = rst_n && !full && (state_q == IDLE);
   assign push         = bus.wr_valid && bus.wr_ready;
   assign clr_win      = !bus.vid_req && (state_q == CLEAR);
   assign buf_win      = !bus.vid_req && (state_q != CLEAR) && !empty;
   assign pop          = buf_win;

   vram_wbuf #(
      .DEPTH (WBUF_DEPTH),
      .W     ($bits(wr_entry_t))
   ) u_wbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sweep_q      <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         vid_rvalid_q <= 1'b0;
         clr_done_q   <= 1'b0;
      end else begin
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         clr_done_q   <= 1'b0;
         vid_rvalid_q <= ram_en_q && !ram_we_q;

         // Idle slots leave ram_addr/ram_wdata untouched.
         if (bus.vid_req) begin
            ram_en_q   <= 1'b1;
            ram_addr_q <= bus.vid_addr;
         end else if (clr_win) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= sweep_q;
            ram_wdata_q <= CLR_COLOR;
         end else if (buf_win) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= head.addr;
            ram_wdata_q <= head.data;
         end

         case (state_q)
            IDLE:  if (bus.clr_req) state_q <= DRAIN;
            DRAIN: if (count == '0) state_q <= CLEAR;
            CLEAR: begin
               // Sweep advances only on slots it actually wins, so video pauses it.
               if (clr_win) begin
                  if (sweep_q == ADDR_W'(PIX_COUNT - 1)) begin
                     sweep_q    <= '0;
                     clr_done_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     sweep_q <= sweep_q + ADDR_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ram_en     = ram_en_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.vid_rvalid = vid_rvalid_q;
   assign bus.vid_rdata  = bus.ram_rdata;
   assign bus.clr_busy   = (state_q != IDLE);
   assign bus.clr_done   = clr_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected RAM traffic, a negedge monitor checks it.
module tb_vram_arbiter;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vram_arbiter_if bus();

   vram_arbiter #(
      .PIX_COUNT  (PIX_COUNT),
      .WBUF_DEPTH (WBUF_DEPTH),
      .CLR_COLOR  (CLR_COLOR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; bit is_clr; bit last; } wexp_t;
   typedef struct { logic [ADDR_W-1:0] addr; int cyc; } rexp_t;
   typedef struct { logic [DATA_W-1:0] data; int cyc; } dexp_t;

   wexp_t wq[$];
   rexp_t vq[$];
   dexp_t rq[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit busy_flag = 1'b0;
   int busy_from = 0;
   int clr_seen = 0;
   int done_cnt = 0;
   int acc_total = 0;
   int en_cnt = 0;

   // RAM model: read data is a fixed function of the address.
   function automatic logic [DATA_W-1:0] hash(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h78;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= hash(bus.ram_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected DUT activity (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      wexp_t e;
      rexp_t v;
      dexp_t r;
      bit exp_done;
      bit exp_busy;
      if (rst_n) begin
         exp_done = 1'b0;
         while (vq.size() > 0 && vq[0].cyc + 1 < cyc) begin
            flag("rd_missing");
            void'(vq.pop_front());
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            flag("rvalid_missing");
            void'(rq.pop_front());
         end
         if (bus.ram_en) en_cnt++;
         if (bus.ram_en && bus.ram_we) begin
            if (wq.size() == 0) flag("wr_spurious");
            else begin
               e = wq.pop_front();
               chk(e.is_clr ? "clr_wr_addr" : "wr_addr", bus.ram_addr, e.addr);
               chk(e.is_clr ? "clr_wr_data" : "wr_data", bus.ram_wdata, e.data);
               if (e.is_clr) clr_seen++;
               if (e.last) begin
                  exp_done  = 1'b1;
                  busy_flag = 1'b0;
               end
            end
         end
         if (bus.ram_en && !bus.ram_we) begin
            if (vq.size() == 0) flag("rd_spurious");
            else begin
               v = vq.pop_front();
               chk("rd_addr", bus.ram_addr, v.addr);
               chk("rd_latency", cyc, v.cyc + 1);
               rq.push_back('{hash(v.addr), v.cyc + 2});
            end
         end
         if (bus.vid_rvalid) begin
            if (rq.size() == 0) flag("rvalid_spurious");
            else begin
               r = rq.pop_front();
               chk("vid_rdata", bus.vid_rdata, r.data);
               chk("rvalid_latency", cyc, r.cyc);
            end
         end
         if (bus.clr_done) done_cnt++;
         if (bus.clr_done || exp_done) chk("clr_done", bus.clr_done, exp_done);
         exp_busy = busy_flag && (cyc >= busy_from);
         chk("clr_busy", bus.clr_busy, exp_busy);
         if (exp_busy) chk("wr_ready_in_clear", bus.wr_ready, 0);
      end
   end

   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         if (bus.wr_valid && bus.wr_ready) begin
            wq.push_back('{bus.wr_addr, bus.wr_data, 1'b0, 1'b0});
            acc_total++;
         end
         if (bus.clr_req && !busy_flag) begin
            for (int i = 0; i < int'(PIX_COUNT); i++)
               wq.push_back('{ADDR_W'(i), CLR_COLOR, 1'b1, (i == int'(PIX_COUNT) - 1)});
            busy_flag = 1'b1;
            busy_from = cyc + 1;
         end
         if (bus.vid_req) vq.push_back('{bus.vid_addr, cyc});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.vid_req  = 1'b0;
      bus.wr_valid = 1'b0;
      bus.clr_req  = 1'b0;
   endtask

   task automatic rand_inputs(input int vid_pct);
      bus.vid_req  = ($urandom_range(0, 99) < vid_pct);
      bus.vid_addr = ADDR_W'($urandom);
      bus.wr_valid = ($urandom_range(0, 2) != 0);
      bus.wr_addr  = ADDR_W'($urandom);
      bus.wr_data  = DATA_W'($urandom);
   endtask

   task automatic check_reset_outputs();
      chk("rst_ram_en", bus.ram_en, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_wdata", bus.ram_wdata, 0);
      chk("rst_vid_rvalid", bus.vid_rvalid, 0);
      chk("rst_clr_busy", bus.clr_busy, 0);
      chk("rst_clr_done", bus.clr_done, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
   endtask

   initial begin
      int n0;
      int base;
      int k;
      int en0;
      bus.vid_addr = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      set_idle();

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_wr_ready", bus.wr_ready, 1);
      chk("post_rst_ram_en", bus.ram_en, 0);

      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h0123;
      step();
      bus.vid_req = 1'b0;
      repeat (3) step();

      n0 = acc_total;
      bus.vid_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.vid_addr = ADDR_W'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = ADDR_W'($urandom);
         bus.wr_data  = DATA_W'($urandom);
         step();
      end
      chk("buf_accepted", acc_total - n0, 4);
      chk("buf_full_ready", bus.wr_ready, 0);
      chk("buf_no_ram_wr", wq.size(), 4);
      set_idle();
      repeat (6) step();
      chk("buf_drained", wq.size(), 0);
      chk("buf_ready_again", bus.wr_ready, 1);

      for (int i = 0; i < 3000; i++) begin
         rand_inputs(50);
         step();
      end

      set_idle();
      repeat (8) step();
      n0 = acc_total;
      bus.vid_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.vid_addr = ADDR_W'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = ADDR_W'($urandom);
         bus.wr_data  = DATA_W'($urandom);
         step();
      end
      chk("backlog_accepted", acc_total - n0, 2);
      set_idle();
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      base = clr_seen;
      k = 0;
      while (busy_flag && k < 40000) begin
         rand_inputs(0);
         bus.vid_req = (k % 4 == 0);
         bus.clr_req = (k == 1000);
         step();
         k++;
      end
      set_idle();
      chk("clr1_finished", busy_flag, 0);
      chk("clr1_writes", clr_seen - base, PIX_COUNT);
      chk("clr1_done_count", done_cnt, 1);
      chk("clr1_ready_after", bus.wr_ready, 1);

      for (int i = 0; i < 500; i++) begin
         rand_inputs(40);
         step();
      end

      set_idle();
      repeat (8) step();
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      base = clr_seen;
      k = 0;
      while ((clr_seen - base) < 5000 && k < 10000) begin
         bus.vid_req  = (k % 4 == 0);
         bus.vid_addr = ADDR_W'($urandom);
         step();
         k++;
      end
      chk("clr2_reached_5000", ((clr_seen - base) >= 5000), 1);
      set_idle();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      wq.delete();
      vq.delete();
      rq.delete();
      busy_flag = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_wr_ready", bus.wr_ready, 1);
      chk("rel_clr_busy", bus.clr_busy, 0);
      en0 = en_cnt;
      repeat (100) step();
      chk("rel_no_ram_access", en_cnt - en0, 0);

      chk("end_wq_empty", wq.size(), 0);
      chk("end_vq_empty", vq.size(), 0);
      chk("end_rq_empty", rq.size(), 0);
      chk("end_done_count", done_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
